// File: rtl/mul_seq_pkg.sv
// Shared types and WIDTH-derived constants for the radix-4 Booth sequencer.
package mul_seq_pkg;

    localparam int MUL_WIDTH  = 32;
    localparam int K_SIGNED   = MUL_WIDTH / 2;
    localparam int K_UNSIGNED = MUL_WIDTH / 2 + 1;
    localparam int ACC_WIDTH  = 2 * MUL_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef struct packed {
        logic single;
        logic double;
        logic neg;
    } booth_digit_t;

    function automatic int k_signed(int w);
        return w / 2;
    endfunction

    function automatic int k_unsigned(int w);
        return w / 2 + 1;
    endfunction

    function automatic int acc_width(int w);
        return 2 * w + 2;
    endfunction

    // Window {X[2i+1], X[2i], X[2i-1]} -> digit in {-2..+2}
    function automatic booth_digit_t booth_decode(logic [2:0] b);
        booth_digit_t d;
        d.single = b[0] ^ b[1];
        d.double = (b == 3'b011) || (b == 3'b100);
        d.neg    = b[2] & ~(b[1] & b[0]);
        return d;
    endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Combinational Booth digit encoder and partial-product selector.
import mul_seq_pkg::*;

module booth_digit_sel #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [2:0]       bits_i,
    input  logic [WIDTH:0]   y_ext_i,
    output logic [WIDTH+1:0] pp_o,
    output logic             neg_o
);

    booth_digit_t     dig;
    logic [WIDTH+1:0] mag;

    assign dig = booth_decode(bits_i);

    always_comb begin
        mag = '0;
        unique case (1'b1)
            dig.single: mag = {y_ext_i[WIDTH], y_ext_i};
            dig.double: mag = {y_ext_i, 1'b0};
            default:    mag = '0;
        endcase
    end

    // One's complement here; the +1 enters as carry-in at the accumulator
    assign pp_o  = dig.neg ? ~mag : mag;
    assign neg_o = dig.neg;

endmodule

// File: rtl/booth_mul_sequencer.sv
// Iterative radix-4 Booth multiplier, one digit per clock.
// Optional early termination: define MUL_EARLY_TERM_EN.
import mul_seq_pkg::*;

module booth_mul_sequencer #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int KS = k_signed(WIDTH);
    localparam int KU = k_unsigned(WIDTH);
    localparam int AW = acc_width(WIDTH);
    localparam int CW = $clog2(KU + 1);
    localparam int XW = WIDTH + 3;

    state_t             state_q;
    logic [XW-1:0]      x_q;
    logic [XW-1:0]      x_d;
    logic [WIDTH:0]     y_q;
    logic               sgn_q;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;
    logic [CW-1:0]      i_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] out_product_q;

    logic [WIDTH+1:0]   pp;
    logic               neg;
    logic [AW-1:0]      pp_ext;
    logic [AW-1:0]      addend;
    logic               last;
    logic               early;

    booth_digit_sel #(
        .WIDTH(WIDTH)
    ) u_sel (
        .bits_i (x_q[2:0]),
        .y_ext_i(y_q),
        .pp_o   (pp),
        .neg_o  (neg)
    );

    assign pp_ext = {{(AW-WIDTH-2){pp[WIDTH+1]}}, pp} + AW'(neg);
    assign addend = pp_ext << {i_q, 1'b0};
    assign acc_d  = acc_q + addend;

    // x_q holds {X_ext, X[-1]} shifted so the current window sits at [2:0]
    assign x_d  = {{2{x_q[XW-1]}}, x_q[XW-1:2]};
    assign last = (i_q == (sgn_q ? CW'(KS - 1) : CW'(KU - 1)));

`ifdef MUL_EARLY_TERM_EN
    assign early = ~|x_q[XW-1:2] | (sgn_q & (&x_q[XW-1:2]));
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            sgn_q         <= 1'b0;
            acc_q         <= '0;
            i_q           <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            out_product_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q        <= {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
                        y_q        <= {in_signed & in_a[WIDTH-1], in_a};
                        sgn_q      <= in_signed;
                        acc_q      <= '0;
                        i_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    x_q   <= x_d;
                    i_q   <= i_q + 1'b1;
                    if (last || early) begin
                        out_product_q <= acc_d[2*WIDTH-1:0];
                        out_valid_q   <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_product = out_product_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Scoreboard bench for booth_mul_sequencer with a behavioural product model.
module tb_booth_mul_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid = 1'b0;
    logic          in_signed = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [2*W-1:0] out_product;

    typedef struct {
        logic [2*W-1:0] prod;
        int             hs;
        int             lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   rand_rdy = 1'b0;

    booth_mul_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_signed  (in_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input bit s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Number of digit cycles the block should spend on multiplier b
    function automatic int ref_digits(input logic [W-1:0] b, input bit s);
        int k = s ? W / 2 : W / 2 + 1;
`ifdef MUL_EARLY_TERM_EN
        logic [W+1:0] xe = s ? {{2{b[W-1]}}, b} : {2'b00, b};
        for (int n = 1; n < k; n++) begin
            logic [W+1:0] rem;
            logic [W+1:0] ones;
            rem  = xe >> (2 * n - 1);
            ones = {(W+2){1'b1}} >> (2 * n - 1);
            if (rem == '0 || (s && rem == ones)) return n;
        end
`endif
        return k;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit s);
        int t = 0;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_signed = s;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        exp_q.push_back('{ref_prod(a, b, s), cyc, ref_digits(b, s)});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("idle_in_ready", 64'(in_ready), 64'd1);
                check("idle_out_valid", 64'(out_valid), 64'd0);
                check("idle_busy", 64'(busy), 64'd0);
            end else begin
                int n;
                n = cyc - exp_q[0].hs + 1;
                check("busy", 64'(busy), 64'(n <= exp_q[0].lat));
                check("out_valid", 64'(out_valid), 64'(n >= exp_q[0].lat + 1));
                check("in_ready", 64'(in_ready), 64'd0);
                if (out_valid) check("product", out_product, exp_q[0].prod);
                if (out_valid && out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           hs;
        int           t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_product", out_product, 64'd0);
        rst_n = 1'b1;

        issue(32'hFFFF_FFFD, 32'd7, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        issue(32'h1234_5678, 32'd1, 1'b1);
        issue(32'h1234_5678, 32'd0, 1'b1);
        issue(32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        issue(32'd0, 32'hFFFF_FFFF, 1'b0);
        wait_empty();

        // Backpressure with a competing request held on the input
        @(negedge clk);
        out_ready = 1'b0;
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        in_a = 32'd11;
        in_b = 32'd13;
        in_signed = 1'b1;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        issue(32'd11, 32'd13, 1'b1);
        wait_empty();

        // Reset in the middle of an operation
        issue(32'h1357_9BDF, 32'h5A5A_5A5A, 1'b1);
        hs = exp_q[0].hs;
        while (cyc - hs + 1 < 8) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd5, 32'd6, 1'b0);
        wait_empty();

        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 5) == 0) b = ~32'($urandom_range(0, 40));
            issue(a, b, 1'($urandom_range(0, 1)));
        end
        wait_empty();
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
